// File: rtl/fir_tap_window.sv
// fir_tap_window: input stage of the FIR MAC unit.
// Keeps a TAPS-deep delay line of signed samples and a writable coefficient
// bank, both presented in parallel to the MAC stage. VOUT flags cycles on which
// a freshly shifted window is presented.
// Optional build macro: ZERO_PAD_EN -- treat the delay line as zero-prefilled so
// VOUT pulses after every accepted sample, including while still filling.
module fir_tap_window #(
  parameter  int DATA_WIDTH = 13,
  parameter  int TAPS       = 8,
  localparam int AW         = (TAPS > 1) ? $clog2(TAPS) : 1,
  localparam int CW         = $clog2(TAPS + 1)
) (
  input  logic                         CLK,
  input  logic                         RST_n,
  input  logic signed [DATA_WIDTH-1:0] DIN,
  input  logic                         VIN,
  input  logic                         FLUSH,
  input  logic                         COEF_WE,
  input  logic        [AW-1:0]         COEF_ADDR,
  input  logic signed [DATA_WIDTH-1:0] COEF_DIN,
  output logic signed [DATA_WIDTH-1:0] TP_W [0:TAPS-1],
  output logic signed [DATA_WIDTH-1:0] H    [0:TAPS-1],
  output logic                         VOUT,
  output logic                         FULL,
  output logic        [CW-1:0]         FILL_CNT
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    RUN  = 2'd2
  } state_t;

  localparam logic [CW-1:0] CNT_FULL = CW'(TAPS);

  state_t          state_reg, state_next;
  logic [CW-1:0]   cnt_reg, cnt_next;
  logic            vout_reg, vout_next;
  logic            accept;

  // Value each tap loads on a shift: the new sample for tap 0, else its neighbour.
  logic signed [DATA_WIDTH-1:0] shift_in [0:TAPS-1];

  // A sample is taken only when a flush does not override it.
  assign accept = VIN & ~FLUSH;

  genvar gi;
  generate
    for (gi = 0; gi < TAPS; gi++) begin : g_tap
      if (gi == 0) begin : g_head
        assign shift_in[gi] = DIN;
      end else begin : g_body
        assign shift_in[gi] = TP_W[gi-1];
      end

      // Delay-line stage: cleared by flush, shifts on a valid sample, else holds.
      always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
          TP_W[gi] <= '0;
        end else if (FLUSH) begin
          TP_W[gi] <= '0;
        end else if (VIN) begin
          TP_W[gi] <= shift_in[gi];
        end
      end

      // Coefficient entry: written when addressed; flush leaves it alone.
      always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
          H[gi] <= '0;
        end else if (COEF_WE && (COEF_ADDR == AW'(gi))) begin
          H[gi] <= COEF_DIN;
        end
      end
    end
  endgenerate

  // Fill-state register, sample counter and registered window strobe.
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      vout_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      vout_reg  <= vout_next;
    end
  end

  // Next fill state and counter; the strobe follows the post-update count.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    vout_next  = 1'b0;

    case (state_reg)
      IDLE: begin
        if (accept) begin
          cnt_next   = CW'(1);
          state_next = (CNT_FULL == CW'(1)) ? RUN : FILL;
        end
      end
      FILL: begin
        if (accept) begin
          cnt_next = cnt_reg + CW'(1);
          if (cnt_next == CNT_FULL) begin
            state_next = RUN;
          end
        end
      end
      RUN: begin
        cnt_next = CNT_FULL;
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase

    if (FLUSH) begin
      state_next = IDLE;
      cnt_next   = '0;
    end

`ifdef ZERO_PAD_EN
    vout_next = accept;
`else
    vout_next = accept && (cnt_next == CNT_FULL);
`endif
  end

  assign VOUT     = vout_reg;
  assign FULL     = (state_reg == RUN);
  assign FILL_CNT = cnt_reg;

endmodule

// File: doc/fir_tap_window.md
Name: fir_tap_window

Overview:
Upstream stage of the FIR MAC unit. Accepts a stream of signed samples with a valid strobe and maintains a TAPS-deep delay line. Presents the delay line as the parallel tap window TP_W plus a registered coefficient bank H, both consumed directly by the MAC stage. VOUT marks cycles on which a new, fully populated window is presented.

Parameters:
DATA_WIDTH, 13, sample and coefficient width in bits (signed two's complement)
TAPS, 8, number of filter taps; delay-line depth and coefficient count (>=2)

Ports:
CLK  in  1  clock
RST_n  in  1  asynchronous active-low reset
DIN  in  DATA_WIDTH  signed input sample
VIN  in  1  DIN valid; one sample accepted per cycle with VIN=1
FLUSH  in  1  synchronous clear of delay line and fill state
COEF_WE  in  1  coefficient write enable
COEF_ADDR  in  $clog2(TAPS)  coefficient index
COEF_DIN  in  DATA_WIDTH  signed coefficient write data
TP_W  out  DATA_WIDTH x [0:TAPS-1]  tap window; TP_W[0] newest, TP_W[TAPS-1] oldest
H  out  DATA_WIDTH x [0:TAPS-1]  coefficient bank
VOUT  out  1  one-cycle strobe: TP_W updated with a new valid window
FULL  out  1  level: delay line holds TAPS real samples
FILL_CNT  out  $clog2(TAPS+1)  number of real samples held, saturates at TAPS

Behaviour:
- Reset (RST_n low, async): TP_W all 0, H all 0, VOUT 0, FULL 0, FILL_CNT 0, state IDLE. Reset mid-operation discards everything, including coefficients.
- Clock is CLK; all state updates on rising edge.
- Shift: on VIN=1 (and FLUSH=0): TP_W[0]<=DIN, TP_W[i]<=TP_W[i-1] for i=1..TAPS-1. Oldest sample is dropped. VIN=0: TP_W holds.
- FILL_CNT increments on each accepted sample and saturates at TAPS. No wrap.
- States:
  - IDLE: FILL_CNT=0; accepted sample -> FILL. If TAPS==1 is ever permitted, go direct to RUN (TAPS>=2 required).
  - FILL: 0<FILL_CNT<TAPS; sample making FILL_CNT=TAPS -> RUN.
  - RUN: FULL=1; stays until FLUSH or reset.
- VOUT: registered. Equals 1 in the cycle after an accepted sample whose update leaves FILL_CNT==TAPS; otherwise 0. Latency DIN->TP_W[0] and VIN->VOUT is 1 cycle. Back-to-back VIN yields back-to-back VOUT in RUN.
- FLUSH: next edge TP_W all 0, FILL_CNT 0, FULL 0, VOUT 0, state IDLE. H is retained. FLUSH has priority over a simultaneous VIN; that sample is dropped.
- Coefficients: COEF_WE=1 writes H[COEF_ADDR]<=COEF_DIN on the edge; other entries are unchanged. A write is allowed in any state. COEF_ADDR>=TAPS is ignored.
- Simultaneous COEF_WE and VIN: both take effect on the same edge, so the window flagged by VOUT is paired with the updated H.
- Simultaneous COEF_WE and FLUSH: the coefficient write still occurs.
- No backpressure; the downstream MAC accepts every cycle.

Optional Feature:
ZERO_PAD_EN. When defined, the delay line is treated as zero-prefilled: VOUT pulses the cycle after every accepted sample, including in FILL (window contains real samples plus zeros). FULL and FILL_CNT are unchanged. Without the macro, VOUT is suppressed until FILL_CNT reaches TAPS, per Behaviour.

Test Plan:
- Reset: drive RST_n=0 with random inputs -> TP_W, H, VOUT, FULL, FILL_CNT all 0; async clear mid-cycle observed without a clock edge.
- Fill (TAPS=8, DATA_WIDTH=13): DIN=1..8 on 8 consecutive VIN cycles -> VOUT=0 after samples 1-7. After sample 8: VOUT=1, FULL=1, FILL_CNT=8, TP_W={8,7,6,5,4,3,2,1}. Then DIN=9 -> VOUT=1, TP_W={9,8,...,2}.
- Gapped input: in RUN, VIN pattern 1,0,0,1 with DIN=20,x,x,21 -> VOUT pattern 1,0,0,1 (one cycle later); TP_W holds between strobes.
- Coefficients: write H[3]=13'h1FFB (-5) -> next cycle H[3]=-5, others unchanged. Write H[0]=7 in the same cycle as VIN DIN=30 -> same edge gives TP_W[0]=30, H[0]=7. Write to COEF_ADDR=8 is invalid; with a 3-bit index it is unreachable when TAPS=8, so check with TAPS=6, addr 6 -> no change.
- Flush: in RUN assert FLUSH with VIN=1, DIN=99 -> TP_W all 0, FILL_CNT 0, VOUT 0, H retained, 99 not present. Eight new samples are required before the next VOUT.
- Reset mid-fill plus ZERO_PAD_EN: 4 samples, then RST_n pulse -> FILL_CNT 0, H 0. With ZERO_PAD_EN defined: first sample 5 -> VOUT=1, TP_W={5,0,0,0,0,0,0,0}, FULL=0.
